// File: rtl/vga_frame_analyzer_pkg.sv
// Purpose: shared timing defaults, coordinate/box types and lock states for the VGA frame analyzer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The timing defaults match the VGA encoder (800x600, 1040x666 total), so both ends agree.
package vga_frame_analyzer_pkg;

    localparam int CW = 11;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BACK   = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FRONT  = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BACK   = 23;
    localparam int DEF_SYNC_POL = 1;
    localparam int DEF_LOCK_FRAMES = 2;

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_TRAIN,
        ST_LOCKED
    } lock_state_t;

    // Running bounding box; 'any' is clear until the first lit pixel lands in it.
    typedef struct packed {
        logic   any;
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } box_t;

    function automatic box_t box_merge(input box_t b, input coord_t x, input coord_t y);
        box_t r;
        if (!b.any) begin
            r.any = 1'b1;
            r.x0  = x;
            r.x1  = x;
            r.y0  = y;
            r.y1  = y;
        end else begin
            r = b;
            if (x < b.x0) r.x0 = x;
            if (x > b.x1) r.x1 = x;
            if (y < b.y0) r.y0 = y;
            if (y > b.y1) r.y1 = y;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_frame_analyzer_sync_counter.sv
// Purpose: sync assertion-edge detector with reloading position counter and period capture.
// Latency: cnt/period update on the clock edge that samples the sync edge (visible 1 clk later).
// Backpressure: none; paced by sample_en/advance, never stalls.
//
// Ports: clk, rst (async active-high); sample_en samples sync_on (sync already
// normalised to 1 = asserted); advance steps the counters; cnt/cnt_nxt = position
// (current / next); run_len = advances since the last edge; period = run_len
// captured at each edge; edge_pulse = assertion edge seen this cycle.
module vga_frame_analyzer_sync_counter
    import vga_frame_analyzer_pkg::*;
#(
    parameter int TOTAL  = 1040,
    parameter int RELOAD = 856
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic          sync_on,
    input  logic          advance,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic [CW-1:0] run_len,
    output logic [CW-1:0] period,
    output logic          edge_pulse
);

    localparam logic [CW-1:0] LAST_C   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] RELOAD_C = CW'(RELOAD);

    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] run_q;

    assign edge_pulse = sample_en && sync_on && !sync_q;
    assign cnt        = cnt_q;
    assign run_len    = run_q;

    // Position wraps at the nominal total so coordinates keep tracking between
    // syncs; the period measurement is a separate, saturating run counter.
    always_comb begin
        cnt_nxt = cnt_q;
        if (edge_pulse) begin
            cnt_nxt = RELOAD_C;
        end else if (advance) begin
            cnt_nxt = (cnt_q >= LAST_C) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            cnt_q  <= '0;
            run_q  <= '0;
            period <= '0;
        end else begin
            if (sample_en) sync_q <= sync_on;
            cnt_q <= cnt_nxt;
            if (edge_pulse) begin
                period <= run_q;
                // An advance coincident with the edge belongs to the new period.
                run_q  <= advance ? CW'(1) : '0;
            end else if (advance && (run_q != '1)) begin
                run_q <= run_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_frame_analyzer.sv
// Purpose: VGA receive monitor: recovers x/y from syncs, measures timing, tracks lock, extracts lit bbox.
// Latency: x/y/active 1 clk after px_ce; bbox/v_total/frame_done 1 clk after the VSYNC-edge sample.
// Backpressure: none; consumes one pixel per px_ce, never stalls.
//
// Ports: clk, rst (async active-high), px_ce pixel enable, RED/GRN/BLU/HSYNC/VSYNC
// from the encoder; x/y/active describe the last sampled pixel; frame_done pulses
// at each VSYNC assertion; h_total/v_total measured periods; locked; bbox_valid and
// bbox_x0/x1/y0/y1 hold the inclusive lit-pixel box of the previous frame.
module vga_frame_analyzer
    import vga_frame_analyzer_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int SYNC_POL    = DEF_SYNC_POL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          px_ce,
    input  logic [3:0]    RED,
    input  logic [3:0]    GRN,
    input  logic [3:0]    BLU,
    input  logic          HSYNC,
    input  logic          VSYNC,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          frame_done,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          locked,
    output logic          bbox_valid,
    output logic [CW-1:0] bbox_x0,
    output logic [CW-1:0] bbox_x1,
    output logic [CW-1:0] bbox_y0,
    output logic [CW-1:0] bbox_y1
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t   H_ACT_C = coord_t'(H_ACTIVE);
    localparam coord_t   V_ACT_C = coord_t'(V_ACTIVE);
    localparam coord_t   H_TOT_C = coord_t'(H_TOTAL);
    localparam coord_t   V_TOT_C = coord_t'(V_TOTAL);
    localparam logic     POL     = (SYNC_POL != 0);
    localparam logic [2:0] LF    = 3'(LOCK_FRAMES);

    logic   hs_on, vs_on;
    logic   h_edge, v_edge;
    coord_t h_nxt, v_nxt, h_run, v_run;

    assign hs_on = (HSYNC == POL);
    assign vs_on = (VSYNC == POL);

    vga_frame_analyzer_sync_counter #(
        .TOTAL  (H_TOTAL),
        .RELOAD (H_ACTIVE + H_FRONT)
    ) u_hcnt (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (px_ce),
        .sync_on    (hs_on),
        .advance    (px_ce),
        .cnt        (x),
        .cnt_nxt    (h_nxt),
        .run_len    (h_run),
        .period     (h_total),
        .edge_pulse (h_edge)
    );

    // Lines advance on HSYNC edges; a coincident VSYNC reload takes priority.
    vga_frame_analyzer_sync_counter #(
        .TOTAL  (V_TOTAL),
        .RELOAD (V_ACTIVE + V_FRONT)
    ) u_vcnt (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (px_ce),
        .sync_on    (vs_on),
        .advance    (h_edge),
        .cnt        (y),
        .cnt_nxt    (v_nxt),
        .run_len    (v_run),
        .period     (v_total),
        .edge_pulse (v_edge)
    );

    // ---------------- pixel sampling and bounding box ----------------
    logic [3:0] red_q, grn_q, blu_q;
    logic       pix_vld_q;
    logic       lit;
    box_t       run_box_q, box_cand;

    // The pixel sampled on the previous px_ce is judged here, while x/y/active
    // still describe it; on a VSYNC edge it is folded into the published box.
    always_comb begin
        lit      = pix_vld_q && active && ((red_q | grn_q | blu_q) != 4'd0);
        box_cand = lit ? box_merge(run_box_q, x, y) : run_box_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q      <= '0;
            grn_q      <= '0;
            blu_q      <= '0;
            pix_vld_q  <= 1'b0;
            active     <= 1'b0;
            frame_done <= 1'b0;
            run_box_q  <= '0;
            bbox_valid <= 1'b0;
            bbox_x0    <= '0;
            bbox_x1    <= '0;
            bbox_y0    <= '0;
            bbox_y1    <= '0;
        end else begin
            pix_vld_q  <= px_ce;
            frame_done <= v_edge;
            if (px_ce) begin
                red_q  <= RED;
                grn_q  <= GRN;
                blu_q  <= BLU;
                active <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
            end
            if (v_edge) begin
                run_box_q  <= '0;
                bbox_valid <= box_cand.any;
                bbox_x0    <= box_cand.any ? box_cand.x0 : '0;
                bbox_x1    <= box_cand.any ? box_cand.x1 : '0;
                bbox_y0    <= box_cand.any ? box_cand.y0 : '0;
                bbox_y1    <= box_cand.any ? box_cand.y1 : '0;
            end else begin
                run_box_q  <= box_cand;
            end
        end
    end

    // ---------------- lock FSM ----------------
    lock_state_t state_q, state_nxt;
    logic [2:0]  good_q, good_nxt;
    logic        line_bad_q;
    logic        h_bad, v_bad, frame_bad;

    assign h_bad     = h_edge && (h_run != H_TOT_C);
    assign v_bad     = (v_run != V_TOT_C);
    assign frame_bad = line_bad_q || h_bad || v_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            good_q     <= '0;
            line_bad_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            good_q  <= good_nxt;
            if (v_edge)     line_bad_q <= 1'b0;
            else if (h_bad) line_bad_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        good_nxt  = good_q;
        unique case (state_q)
            ST_HUNT: begin
                if (v_edge) begin
                    state_nxt = ST_TRAIN;
                    good_nxt  = '0;
                end
            end
            ST_TRAIN: begin
                if (v_edge) begin
                    if (frame_bad) begin
                        good_nxt = '0;
                    end else if ((good_q + 3'd1) >= LF) begin
                        state_nxt = ST_LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_q + 3'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_bad || (v_edge && v_bad)) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

endmodule
